// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor
//   Watches the q output and load strobe of an upstream loadable counter.
//   Every enabled clock it compares the step prev_q -> q_in against the
//   expected +1/-1 step, flags illegal steps, detects wrap-around, keeps a
//   saturating wrap count and raises a held interrupt once that count
//   reaches a programmable threshold (arm / fire / ack handshake).
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   q_in         counter output being monitored
//   load_in      load strobe also driven into the counter
//   enable       sampling enable; low drops the step history
//   arm          clear wrap_count and arm the interrupt
//   ack          acknowledge a fired interrupt
//   clear_err    clear the sticky sequence-error flag
//   threshold    wrap count at which irq fires
//   wrap_pulse   one-cycle pulse per detected wrap
//   wrap_count   wraps since last arm, saturating
//   irq          interrupt level, held until ack
//   seq_err      sticky illegal-step flag
//   state_o      FSM state: 00 IDLE, 01 ARMED, 10 FIRED
module count_wrap_monitor #(
  parameter int CNT_W  = 3,
  parameter int WCNT_W = 8,
  parameter int DIR    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  q_in,
  input  logic              load_in,
  input  logic              enable,
  input  logic              arm,
  input  logic              ack,
  input  logic              clear_err,
  input  logic [WCNT_W-1:0] threshold,
  output logic              wrap_pulse,
  output logic [WCNT_W-1:0] wrap_count,
  output logic              irq,
  output logic              seq_err,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    FIRED = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0]  Q_MAX = '1;
  localparam logic [WCNT_W-1:0] W_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] prev_q;
  logic             prev_valid;
  logic             load_d;

  logic [CNT_W-1:0] exp_q;
  logic             step_chk, step_ok, step_bad, is_wrap, cnt_inc;

  // The counter takes its load value one edge after the strobe, so the
  // step seen now is a load step when the strobe was high last sample.
  always_comb begin
    exp_q    = (DIR == 0) ? prev_q + CNT_W'(1) : prev_q - CNT_W'(1);
    step_chk = enable & prev_valid & ~load_d;
    step_ok  = (q_in == exp_q);
    step_bad = step_chk & ~step_ok;
    if (DIR == 0)
      is_wrap = step_chk & step_ok & (prev_q == Q_MAX) & (q_in == '0);
    else
      is_wrap = step_chk & step_ok & (prev_q == '0) & (q_in == Q_MAX);
    cnt_inc  = is_wrap & (wrap_count != W_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_q     <= '0;
      prev_valid <= 1'b0;
      load_d     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      irq        <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      // A fresh error beats a same-cycle clear.
      if (step_bad)       seq_err <= 1'b1;
      else if (clear_err) seq_err <= 1'b0;

      if (!enable) begin
        // Drop history so the first sample after re-enable only seeds.
        prev_valid <= 1'b0;
        load_d     <= 1'b0;
        wrap_pulse <= 1'b0;
      end else begin
        prev_q     <= q_in;
        prev_valid <= 1'b1;
        load_d     <= load_in;
        wrap_pulse <= is_wrap;

        case (state)
          IDLE: begin
            if (arm) begin
              state      <= ARMED;
              wrap_count <= '0;
            end
          end
          ARMED: begin
            // arm re-clears and outranks both a wrap and the fire check.
            if (arm) begin
              wrap_count <= '0;
            end else begin
              if (wrap_count >= threshold) begin
                state <= FIRED;
                irq   <= 1'b1;
              end
              if (cnt_inc) wrap_count <= wrap_count + WCNT_W'(1);
            end
          end
          FIRED: begin
            // arm is ignored here; ack (alone or with arm) returns to IDLE.
            if (ack) begin
              state <= IDLE;
              irq   <= 1'b0;
            end
            if (cnt_inc) wrap_count <= wrap_count + WCNT_W'(1);
          end
          default: begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_count_wrap_monitor.sv
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] q_in;
  logic       load_in, enable, arm, ack, clear_err;
  logic [7:0] threshold;

  logic       wp_a, irq_a, err_a;
  logic [7:0] wc_a;
  logic [1:0] st_a;
  logic       wp_b, irq_b, err_b;
  logic [1:0] wc_b;
  logic [1:0] st_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_wrap_monitor #(.CNT_W(3), .WCNT_W(8), .DIR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .load_in(load_in), .enable(enable),
    .arm(arm), .ack(ack), .clear_err(clear_err), .threshold(threshold),
    .wrap_pulse(wp_a), .wrap_count(wc_a), .irq(irq_a), .seq_err(err_a), .state_o(st_a)
  );

  count_wrap_monitor #(.CNT_W(3), .WCNT_W(2), .DIR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .load_in(load_in), .enable(enable),
    .arm(arm), .ack(ack), .clear_err(clear_err), .threshold(threshold[1:0]),
    .wrap_pulse(wp_b), .wrap_count(wc_b), .irq(irq_b), .seq_err(err_b), .state_o(st_b)
  );

  typedef struct {
    logic [2:0] q;
    logic       ld, en, arm, ack, clr;
    logic [7:0] thr;
    logic       wp;
    logic [7:0] wc;
    logic       irq, err;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int q, int ld, int en, int a, int k, int c, int thr,
                              int wp, int wc, int irq, int err, int st);
    vec_t v;
    v.q = 3'(q); v.ld = 1'(ld); v.en = 1'(en); v.arm = 1'(a); v.ack = 1'(k);
    v.clr = 1'(c); v.thr = 8'(thr); v.wp = 1'(wp); v.wc = 8'(wc);
    v.irq = 1'(irq); v.err = 1'(err); v.st = 2'(st);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic drive(input logic [2:0] q, input logic ld, en, a, k, c, input logic [7:0] thr);
    @(negedge clk);
    q_in = q; load_in = ld; enable = en; arm = a; ack = k; clear_err = c; threshold = thr;
    @(posedge clk);
    #1;
  endtask

  int npulse;

  initial begin
    rst_n = 1'b0; q_in = '0; load_in = 0; enable = 0; arm = 0; ack = 0;
    clear_err = 0; threshold = '0;

    // ---- vector table: {q, ld, en, arm, ack, clr, thr, wp, wc, irq, err, st}
    // load 5 then count 5,6,7,0,1 while armed (thr 100 never fires)
    add(0,1,1,1,0,0,100, 0,0,0,0,1);
    add(5,0,1,0,0,0,100, 0,0,0,0,1);
    add(6,0,1,0,0,0,100, 0,0,0,0,1);
    add(7,0,1,0,0,0,100, 0,0,0,0,1);
    add(0,0,1,0,0,0,100, 1,1,0,0,1);
    add(1,0,1,0,0,0,100, 0,1,0,0,1);
    // re-arm with threshold 3, free count through three wraps
    add(2,0,1,1,0,0,3,   0,0,0,0,1);
    for (int k = 3; k < 8; k++) add(k,0,1,0,0,0,3, 0,0,0,0,1);
    add(0,0,1,0,0,0,3,   1,1,0,0,1);
    for (int k = 1; k < 8; k++) add(k,0,1,0,0,0,3, 0,1,0,0,1);
    add(0,0,1,0,0,0,3,   1,2,0,0,1);
    for (int k = 1; k < 8; k++) add(k,0,1,0,0,0,3, 0,2,0,0,1);
    add(0,0,1,0,0,0,3,   1,3,0,0,1);
    add(1,0,1,0,0,0,3,   0,3,1,0,2);   // irq one edge after count hits 3
    add(2,0,1,1,0,0,3,   0,3,1,0,2);   // arm alone in FIRED ignored
    add(3,0,1,1,1,0,3,   0,3,0,0,0);   // arm+ack: ack wins, count kept
    for (int k = 4; k < 8; k++) add(k,0,1,0,0,0,3, 0,3,0,0,0);
    add(0,0,1,0,0,0,3,   1,3,0,0,0);   // wrap pulses in IDLE, not counted
    // illegal step 2->5, sticky, then clear
    add(1,0,1,0,0,0,3,   0,3,0,0,0);
    add(2,0,1,0,0,0,3,   0,3,0,0,0);
    add(5,0,1,0,0,0,3,   0,3,0,1,0);
    add(6,0,1,0,0,0,3,   0,3,0,1,0);
    add(7,0,1,0,0,1,3,   0,3,0,0,0);
    // same 2->5 jump announced by load
    add(0,0,1,0,0,0,3,   1,3,0,0,0);
    add(1,0,1,0,0,0,3,   0,3,0,0,0);
    add(2,1,1,0,0,0,3,   0,3,0,0,0);
    add(5,0,1,0,0,0,3,   0,3,0,0,0);
    add(6,0,1,0,0,0,3,   0,3,0,0,0);
    // error coinciding with clear_err wins
    add(3,0,1,0,0,1,3,   0,3,0,1,0);
    add(4,0,1,0,0,1,3,   0,3,0,0,0);
    // threshold 0 fires the cycle after arm
    add(5,0,1,1,0,0,0,   0,0,0,0,1);
    add(6,0,1,0,0,0,0,   0,0,1,0,2);
    add(7,0,1,0,1,0,0,   0,0,0,0,0);
    add(0,0,1,0,1,0,0,   1,0,0,0,0);   // ack in IDLE ignored
    add(1,0,1,1,0,0,3,   0,0,0,0,1);
    add(2,0,1,0,1,0,3,   0,0,0,0,1);   // ack in ARMED ignored
    for (int k = 3; k < 8; k++) add(k,0,1,0,0,0,3, 0,0,0,0,1);
    add(0,0,1,1,0,0,3,   1,0,0,0,1);   // arm beats same-cycle wrap
    for (int k = 1; k < 8; k++) add(k,0,1,0,0,0,3, 0,0,0,0,1);
    add(0,0,0,0,0,0,3,   0,0,0,0,1);   // disabled 7->0: no wrap
    add(0,0,1,0,0,0,3,   0,0,0,0,1);   // 0->0 only seeds, no error
    add(1,0,1,0,0,0,3,   0,0,0,0,1);

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", {wp_a, wc_a, irq_a, err_a, st_a}, '0);
    chk("reset_b", {wp_b, wc_b, irq_b, err_b, st_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].q, tbl[i].ld, tbl[i].en, tbl[i].arm, tbl[i].ack, tbl[i].clr, tbl[i].thr);
      chk($sformatf("row%0d", i), {wp_a, wc_a, irq_a, err_a, st_a},
          {tbl[i].wp, tbl[i].wc, tbl[i].irq, tbl[i].err, tbl[i].st});
    end

    // ---- saturation: arm thr 3, six wraps; 2-bit counter sticks at 3
    drive(3'd2, 0, 1, 1, 0, 0, 8'd3);
    chk("sat_arm_a", {wc_a, st_a}, {8'd0, 2'b01});
    chk("sat_arm_b", {wc_b, st_b}, {2'd0, 2'b01});
    npulse = 0;
    for (int s = 3; s <= 50; s++) begin
      drive(3'(s), 0, 1, 0, 0, 0, 8'd3);
      if (wp_a) npulse++;
    end
    chk("wrap_pulses", npulse, 6);
    chk("sat_a", {wc_a, irq_a, st_a}, {8'd6, 1'b1, 2'b10});
    chk("sat_b", {wc_b, irq_b, st_b}, {2'd3, 1'b1, 2'b10});

    // illegal step while FIRED, then async reset between edges
    drive(3'd5, 0, 1, 0, 0, 0, 8'd3);
    chk("err_fired_a", {err_a, irq_a}, 2'b11);
    chk("err_fired_b", {err_b, irq_b}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", {wp_a, wc_a, irq_a, err_a, st_a}, '0);
    chk("async_rst_b", {wp_b, wc_b, irq_b, err_b, st_b}, '0);
    @(negedge clk);
    chk("rst_hold_a", {irq_a, st_a}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
